// File: rtl/axi_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : axi_traffic_gen
// Brief    : AXI4 master stimulus engine. On START it writes NUM_TXN
//            single-beat INCR transfers of a seeded pattern, reads the same
//            addresses back, counts data mismatches and flags bad responses.
// Revision : 1.0 - initial release
// ============================================================================
module axi_traffic_gen #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    NUM_TXN    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]           SEED       = 32'hA5A5_0000
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      START,
  // write address channel
  output logic [ID_WIDTH-1:0]       AWID,
  output logic [ADDR_WIDTH-1:0]     AWADDR,
  output logic [7:0]                AWLEN,
  output logic [2:0]                AWSIZE,
  output logic [1:0]                AWBURST,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  // write data channel
  output logic [DATA_WIDTH-1:0]     WDATA,
  output logic [DATA_WIDTH/8-1:0]   WSTRB,
  output logic                      WLAST,
  output logic                      WVALID,
  input  logic                      WREADY,
  // write response channel
  input  logic [ID_WIDTH-1:0]       BID,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  output logic                      BREADY,
  // read address channel
  output logic [ID_WIDTH-1:0]       ARID,
  output logic [ADDR_WIDTH-1:0]     ARADDR,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  // read data channel
  input  logic [ID_WIDTH-1:0]       RID,
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST,
  input  logic                      RVALID,
  output logic                      RREADY,
  // status
  output logic                      BUSY,
  output logic                      DONE,
  output logic [15:0]               ERR_COUNT,
  output logic                      RESP_ERR
);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_wr_req  = 3'd1;
  localparam logic [2:0] c_st_wr_resp = 3'd2;
  localparam logic [2:0] c_st_rd_req  = 3'd3;
  localparam logic [2:0] c_st_rd_data = 3'd4;
  localparam logic [2:0] c_st_done    = 3'd5;

  localparam logic [2:0]            c_size   = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [15:0]           c_last   = 16'(NUM_TXN - 1);
  localparam logic [ADDR_WIDTH-1:0] c_stride = ADDR_WIDTH'(DATA_WIDTH / 8);

  logic [2:0]  state_q,     state_d;
  logic [15:0] idx_q,       idx_d;
  logic        awvalid_q,   awvalid_d;
  logic        wvalid_q,    wvalid_d;
  logic        arvalid_q,   arvalid_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic [15:0] err_count_q, err_count_d;
  logic        resp_err_q,  resp_err_d;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [31:0]           w_pattern;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_b_err;
  logic                  w_r_err;

  // Address and pattern are pure functions of the transaction index, so the
  // same values serve the write and the read-back phases.
  assign w_addr    = BASE_ADDR + ADDR_WIDTH'(idx_q) * c_stride;
  assign w_pattern = SEED + {16'd0, idx_q};
  assign w_data    = {(DATA_WIDTH / 32){w_pattern}};
  assign w_b_err   = (BRESP != 2'b00) || (BID != '0);
  assign w_r_err   = (RRESP != 2'b00) || (RID != '0) || !RLAST;

  // Next-state logic: one transaction in flight, VALIDs come only from flops.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_count_d = err_count_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      c_st_idle, c_st_done: begin
        if (START) begin
          state_d     = c_st_wr_req;
          idx_d       = 16'd0;
          awvalid_d   = 1'b1;
          wvalid_d    = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_count_d = 16'd0;
          resp_err_d  = 1'b0;
        end
      end
      c_st_wr_req: begin
        // AW and W retire independently; leave once both have handshaken.
        if (AWREADY) awvalid_d = 1'b0;
        if (WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = c_st_wr_resp;
      end
      c_st_wr_resp: begin
        if (BVALID) begin
          if (w_b_err) resp_err_d = 1'b1;
          if (idx_q == c_last) begin
            idx_d     = 16'd0;
            state_d   = c_st_rd_req;
            arvalid_d = 1'b1;
          end else begin
            idx_d     = idx_q + 16'd1;
            state_d   = c_st_wr_req;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end
        end
      end
      c_st_rd_req: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = c_st_rd_data;
        end
      end
      c_st_rd_data: begin
        if (RVALID) begin
          if ((RDATA != w_data) && (err_count_q != 16'hFFFF))
            err_count_d = err_count_q + 16'd1;
          if (w_r_err) resp_err_d = 1'b1;
          if (idx_q == c_last) begin
            state_d = c_st_done;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d     = idx_q + 16'd1;
            state_d   = c_st_rd_req;
            arvalid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = c_st_idle;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any handshake in progress immediately.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= c_st_idle;
      idx_q       <= 16'd0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_count_q <= 16'd0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_count_q <= err_count_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign AWID      = '0;
  assign AWADDR    = w_addr;
  assign AWLEN     = 8'd0;
  assign AWSIZE    = c_size;
  assign AWBURST   = 2'b01;
  assign AWVALID   = awvalid_q;
  assign WDATA     = w_data;
  assign WSTRB     = '1;
  assign WLAST     = 1'b1;
  assign WVALID    = wvalid_q;
  assign BREADY    = (state_q == c_st_wr_resp);
  assign ARID      = '0;
  assign ARADDR    = w_addr;
  assign ARLEN     = 8'd0;
  assign ARSIZE    = c_size;
  assign ARBURST   = 2'b01;
  assign ARVALID   = arvalid_q;
  assign RREADY    = (state_q == c_st_rd_data);
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR_COUNT = err_count_q;
  assign RESP_ERR  = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_traffic_gen
// Brief    : Self-checking bench for axi_traffic_gen with a small AXI memory
//            slave whose ready delay, read corruption and write response are
//            selected per pass from a vector table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_traffic_gen;

  localparam int c_n = 4;

  logic        clk;
  logic        ARESET, START;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [63:0] WDATA, RDATA;
  logic [7:0]  WSTRB;
  logic        BUSY, DONE, RESP_ERR;
  logic [15:0] ERR_COUNT;

  axi_traffic_gen #(.NUM_TXN(c_n)) dut (
    .ACLK(clk), .ARESET(ARESET), .START(START),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY),
    .BUSY(BUSY), .DONE(DONE), .ERR_COUNT(ERR_COUNT), .RESP_ERR(RESP_ERR)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int aw_delay;
    int flip_txn;
    int bresp_txn;
    int exp_err;
    bit exp_resp;
  } vec_t;

  // configuration, written only by the main sequence
  int cfg_aw_delay = 0;
  int cfg_flip_txn = -1;
  int cfg_bresp_txn = -1;
  int pass_id = 0;

  // slave observations, written only by the slave process
  logic [31:0] aw_addr_a [8];
  logic [63:0] w_data_a  [8];
  int          aw_hi_a   [8];
  int          w_hi_a    [8];
  bit          aw_stab_a [8];
  bit          resp_after_b [8];
  int aw_n, w_n, b_n, r_n;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // AXI memory slave: decides READY/VALID at each falling edge, so every
  // handshake it predicts completes on the following rising edge.
  initial begin : slave
    logic [63:0] mem [8];
    logic [31:0] first_addr, sv_awaddr, got_addr, sv_araddr, rd_addr;
    logic [63:0] sv_wdata, got_data;
    bit aw_fire, w_fire, b_fire, ar_fire, r_fire, got_aw, got_w, rd_pend, cur_stab;
    int cur_aw_hi, cur_w_hi, aw_wait, wr_issue, rd_issue, seen_pass;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; BID = 0;
    ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0; RID = 0; RLAST = 0;
    aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
    got_aw = 0; got_w = 0; rd_pend = 0; cur_stab = 1;
    cur_aw_hi = 0; cur_w_hi = 0; aw_wait = 0; wr_issue = 0; rd_issue = 0;
    seen_pass = 0; aw_n = 0; w_n = 0; b_n = 0; r_n = 0;
    first_addr = 0; sv_awaddr = 0; got_addr = 0; sv_araddr = 0; rd_addr = 0;
    sv_wdata = 0; got_data = 0;
    for (int k = 0; k < 8; k++) mem[k] = 64'd0;
    forever begin
      @(negedge clk);
      if (ARESET) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
        got_aw = 0; got_w = 0; rd_pend = 0; cur_aw_hi = 0; cur_w_hi = 0; aw_wait = 0;
      end else begin
        if (seen_pass != pass_id) begin
          seen_pass = pass_id;
          aw_n = 0; w_n = 0; b_n = 0; r_n = 0; wr_issue = 0; rd_issue = 0;
          cur_aw_hi = 0; cur_w_hi = 0; aw_wait = 0;
        end
        // retire the handshakes that completed on the last rising edge
        if (aw_fire) begin
          if (aw_n < 8) begin
            aw_addr_a[aw_n] = sv_awaddr; aw_hi_a[aw_n] = cur_aw_hi; aw_stab_a[aw_n] = cur_stab;
          end
          aw_n++; cur_aw_hi = 0; aw_wait = 0; got_aw = 1; got_addr = sv_awaddr;
        end
        if (w_fire) begin
          if (w_n < 8) begin
            w_data_a[w_n] = sv_wdata; w_hi_a[w_n] = cur_w_hi;
          end
          w_n++; cur_w_hi = 0; got_w = 1; got_data = sv_wdata;
        end
        if (b_fire) begin
          BVALID = 0;
          if (b_n < 8) resp_after_b[b_n] = RESP_ERR;
          b_n++;
        end
        if (ar_fire) begin rd_pend = 1; rd_addr = sv_araddr; end
        if (r_fire) begin RVALID = 0; r_n++; end
        // drive the next cycle
        if (AWVALID) begin
          cur_aw_hi++;
          if (cur_aw_hi == 1) begin first_addr = AWADDR; cur_stab = 1; end
          else if (AWADDR != first_addr) cur_stab = 0;
          if (aw_wait < cfg_aw_delay) begin AWREADY = 0; aw_wait++; end
          else AWREADY = 1;
        end else AWREADY = 0;
        if (WVALID) begin cur_w_hi++; WREADY = 1; end
        else WREADY = 0;
        if (got_aw && got_w && !BVALID) begin
          mem[got_addr[5:3]] = got_data;
          BVALID = 1;
          BRESP = (wr_issue == cfg_bresp_txn) ? 2'b10 : 2'b00;
          wr_issue++; got_aw = 0; got_w = 0;
        end
        ARREADY = ARVALID;
        if (rd_pend && !RVALID) begin
          RDATA = mem[rd_addr[5:3]];
          if (rd_issue == cfg_flip_txn) RDATA[0] = ~RDATA[0];
          RVALID = 1; RLAST = 1; RRESP = 0; RID = 0;
          rd_issue++; rd_pend = 0;
        end
        aw_fire = AWVALID && AWREADY; sv_awaddr = AWADDR;
        w_fire  = WVALID && WREADY;   sv_wdata  = WDATA;
        b_fire  = BVALID && BREADY;
        ar_fire = ARVALID && ARREADY; sv_araddr = ARADDR;
        r_fire  = RVALID && RREADY;
      end
    end
  end

  task automatic start_pass();
    @(negedge clk); #1;
    pass_id++;
    START = 1;
    @(negedge clk); #1;
    START = 0;
    chk("start_busy", BUSY, 1);
    chk("start_done", DONE, 0);
    chk("start_errcnt", ERR_COUNT, 0);
    chk("start_resperr", RESP_ERR, 0);
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      if (DONE) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    chk(nm, ok, 1);
  endtask

  task automatic finish_pass(input vec_t v);
    logic [31:0] p;
    wait_done("done_timeout");
    for (int i = 0; i < c_n; i++) begin
      p = 32'hA5A5_0000 + 32'(i);
      chk($sformatf("awaddr[%0d]", i), aw_addr_a[i], 64'(i * 8));
      chk($sformatf("wdata[%0d]", i), w_data_a[i], {p, p});
      chk($sformatf("aw_cycles[%0d]", i), aw_hi_a[i], v.aw_delay + 1);
      chk($sformatf("w_cycles[%0d]", i), w_hi_a[i], 1);
      chk($sformatf("aw_stable[%0d]", i), aw_stab_a[i], 1);
    end
    chk("aw_count", aw_n, c_n);
    chk("b_count", b_n, c_n);
    chk("r_count", r_n, c_n);
    chk("done_level", DONE, 1);
    chk("done_busy", BUSY, 0);
    chk("err_count", ERR_COUNT, v.exp_err);
    chk("resp_err", RESP_ERR, v.exp_resp);
    if (v.bresp_txn == 0) chk("resp_err_after_b0", resp_after_b[0], 1);
  endtask

  vec_t tbl [4];
  vec_t clean;

  initial begin : main
    bit ok;
    tbl[0] = '{0, -1, -1, 0, 0};
    tbl[1] = '{0,  2, -1, 1, 0};
    tbl[2] = '{3, -1, -1, 0, 0};
    tbl[3] = '{0, -1,  0, 0, 1};
    clean  = '{0, -1, -1, 0, 0};
    ARESET = 1; START = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_errcnt", ERR_COUNT, 0);
    chk("rst_resperr", RESP_ERR, 0);
    chk("awlen", AWLEN, 0);
    chk("awsize", AWSIZE, 3);
    chk("awburst", AWBURST, 1);
    chk("arburst", ARBURST, 1);
    chk("wstrb", WSTRB, 8'hFF);
    chk("wlast", WLAST, 1);
    chk("awid", AWID, 0);
    ARESET = 0;

    // table-driven passes
    for (int t = 0; t < 4; t++) begin
      cfg_aw_delay = tbl[t].aw_delay;
      cfg_flip_txn = tbl[t].flip_txn;
      cfg_bresp_txn = tbl[t].bresp_txn;
      start_pass();
      finish_pass(tbl[t]);
    end

    // reset during the read-data phase of transaction 1
    cfg_aw_delay = 0; cfg_flip_txn = -1; cfg_bresp_txn = -1;
    start_pass();
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      if (RREADY && r_n == 1) begin ok = 1; break; end
      @(negedge clk); #1;
    end
    chk("reach_rd1", ok, 1);
    #1 ARESET = 1;
    #1;
    chk("arst_arvalid", ARVALID, 0);
    chk("arst_rready", RREADY, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_done", DONE, 0);
    repeat (2) @(negedge clk);
    #1 ARESET = 0;
    start_pass();
    finish_pass(clean);

    // START held high: one pass, DONE for a single cycle, then restart
    @(negedge clk); #1;
    pass_id++;
    START = 1;
    wait_done("held_done_timeout");
    chk("held_done_busy", BUSY, 0);
    pass_id++;
    @(negedge clk); #1;
    chk("held_done_drop", DONE, 0);
    chk("held_rebusy", BUSY, 1);
    chk("held_awvalid", AWVALID, 1);
    chk("held_awaddr", AWADDR, 0);
    START = 0;
    repeat (5) @(negedge clk);
    #1 START = 1;
    @(negedge clk); #1 START = 0;
    repeat (6) @(negedge clk);
    #1 START = 1;
    @(negedge clk); #1 START = 0;
    finish_pass(clean);
    repeat (5) @(negedge clk);
    #1;
    chk("idle_done_hold", DONE, 1);
    chk("idle_busy", BUSY, 0);
    chk("idle_awvalid", AWVALID, 0);
    chk("idle_aw_count", aw_n, c_n);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_traffic_gen.md
Name: axi_traffic_gen

Overview:
- Synthesizable-style AXI4 master stimulus engine for the CORESDR_AXI test environment.
- Driven directly by the bench clock/reset generator.
- On START, issues NUM_TXN single-beat INCR writes of a deterministic pattern, then reads the same addresses back and compares each beat.
- Reports completion, data-mismatch count and sticky response-error status to the bench.

Parameters:
- ADDR_WIDTH, 32: AxADDR width.
- DATA_WIDTH, 64: WDATA/RDATA width; must be a multiple of 32.
- ID_WIDTH, 4: AxID/BID/RID width.
- NUM_TXN, 16: transactions per pass, 1..65535.
- BASE_ADDR, 0: address of transaction 0.
- SEED, 32'hA5A5_0000: pattern seed.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- START  in  1  begin a pass; sampled only in IDLE or DONE.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  ID_WIDTH/ADDR_WIDTH/8/3/2/1  write address channel.
- AWREADY  in  1  write address ready.
- WDATA/WSTRB/WLAST/WVALID  out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- WREADY  in  1  write data ready.
- BID/BRESP/BVALID  in  ID_WIDTH/2/1  write response.
- BREADY  out  1  write response ready.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  as AW channel  read address channel.
- ARREADY  in  1  read address ready.
- RID/RDATA/RRESP/RLAST/RVALID  in  ID_WIDTH/DATA_WIDTH/2/1/1  read data channel.
- RREADY  out  1  read data ready.
- BUSY  out  1  pass in progress.
- DONE  out  1  level; pass complete.
- ERR_COUNT  out  16  read-data mismatches, saturating.
- RESP_ERR  out  1  sticky; any BRESP/RRESP non-zero, BID/RID non-zero, or RLAST=0 on an R beat.

Behaviour:
- Reset (async, immediate): all VALID/READY, BUSY, DONE, RESP_ERR = 0; ERR_COUNT = 0; transaction index i = 0; state IDLE.
- Constant fields: AxID = 0, AxLEN = 0, AxBURST = 2'b01, AxSIZE = log2(DATA_WIDTH/8), WLAST = 1, WSTRB = all ones.
- Address: BASE_ADDR + i*(DATA_WIDTH/8), truncated to ADDR_WIDTH.
- Data: pattern(i) = (SEED + i) mod 2^32, replicated to DATA_WIDTH.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- IDLE/DONE -> WR_REQ when START=1.
  - On that edge: BUSY=1, DONE=0, i=0, ERR_COUNT=0, RESP_ERR=0.
  - AWVALID and WVALID rise on the same edge (1-cycle latency from START).
- WR_REQ: AW and W retire independently.
  - Each VALID is held with stable payload until its own handshake, then drops the next cycle.
  - Simultaneous handshakes in one cycle are legal.
  - Move to WR_RESP once both channels have handshaken.
- WR_RESP: BREADY=1; on BVALID, record any response error.
  - If i = NUM_TXN-1: i=0, go to RD_REQ.
  - Else: i+1, return to WR_REQ (AWVALID/WVALID reassert on the next edge).
- RD_REQ: ARVALID held until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY=1; on RVALID:
  - If RDATA != pattern(i), ERR_COUNT increments, saturating at 16'hFFFF.
  - Record any response error.
  - Last transaction -> DONE; else i+1 -> RD_REQ.
- DONE: BUSY=0, DONE=1. ERR_COUNT and RESP_ERR hold until the next START.
- Protocol rules:
  - VALID never depends combinationally on READY.
  - BREADY and RREADY are low outside their states.
  - Only one outstanding transaction at a time.
- START while BUSY: ignored.
- ARESET mid-pass: abort without completing handshakes; the next START restarts from i=0.

Test Plan:
- Zero-wait memory slave, NUM_TXN=4, START pulse -> AWADDR 0,8,16,24 with WDATA 0xA5A50000A5A50000 .. 0xA5A50003A5A50003; reads return the same; DONE=1, ERR_COUNT=0, RESP_ERR=0.
- AWREADY delayed 3 cycles, WREADY immediate -> WVALID high 1 cycle; AWVALID high 4 cycles with stable AWADDR; exactly one B accepted per transaction.
- Slave flips bit 0 of RDATA on transaction 2 -> ERR_COUNT=1 at DONE; a second START clears it to 0 and a clean pass ends with 0.
- BRESP=2'b10 on transaction 0 -> RESP_ERR=1 from the next cycle, held through DONE; all transactions still issued.
- ARESET asserted for 2 cycles during RD_DATA of transaction 1 -> ARVALID/RREADY/BUSY = 0 without waiting for a clock edge; a subsequent START performs a full clean pass from address 0.
- START held high continuously -> one pass, DONE for 1 cycle, then BUSY reasserts and AWADDR=BASE_ADDR again; START pulses during BUSY have no effect.
